// File: rtl/tdm_demux8.sv
// tdm_demux8: 8-slot TDM demultiplexer, slot-7 sample -> parallel frame on y one edge later; TDM_DEMUX_OVF_CNT_EN adds ovf_cnt.
// Input never stalls; a frame completing while the output is held (yv & !yr) is dropped and flagged on ovf.
module tdm_demux8 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   d,
  input  logic           dv,
  input  logic           sof,
  output logic [8*W-1:0] y,
  output logic           yv,
  input  logic           yr,
  output logic [2:0]     s,
  output logic           err,
`ifdef TDM_DEMUX_OVF_CNT_EN
  output logic           ovf,
  output logic [7:0]     ovf_cnt
`else
  output logic           ovf
`endif
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]     state;
  logic [W-1:0]   stage [0:6];
  logic           accept;
  logic           realign;
  logic           complete;
  logic           consume;
  logic           load;
  logic           drop;
  logic [2:0]     slot;
  logic [8*W-1:0] frame;

  always_comb begin
    accept   = dv && (sof || (state == COLLECT));
    // a qualified sof always forces slot 0, which also covers the realign case
    slot     = sof ? 3'd0 : s;
    realign  = dv && sof && (state == COLLECT) && (s != 3'd0);
    complete = accept && (slot == 3'd7);
    consume  = yv && yr;
    load     = complete && (!yv || yr);
    drop     = complete && yv && !yr;
    frame    = '0;
    for (int k = 0; k < 7; k++) begin
      frame[W*k +: W] = stage[k];
    end
    frame[W*7 +: W] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= 3'd0;
      for (int k = 0; k < 7; k++) begin
        stage[k] <= '0;
      end
    end else if (accept) begin
      state <= COLLECT;
      s     <= slot + 3'd1;
      for (int k = 0; k < 7; k++) begin
        if (slot == 3'(k)) begin
          stage[k] <= d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      yv  <= 1'b0;
      err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      err <= realign;
      ovf <= drop;
      if (load) begin
        y  <= frame;
        yv <= 1'b1;
      end else if (consume) begin
        yv <= 1'b0;
      end
    end
  end

`ifdef TDM_DEMUX_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 8'd0;
    end else if (drop && consume) begin
      ovf_cnt <= 8'd1;
    end else if (drop) begin
      if (ovf_cnt != 8'hFF) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end else if (consume) begin
      ovf_cnt <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 with a frame scoreboard; expected frames are queued as samples are driven.
module tb_tdm_demux8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d;
  logic        dv;
  logic        sof;
  logic [63:0] y;
  logic        yv;
  logic        yr;
  logic [2:0]  s;
  logic        err;
  logic        ovf;
`ifdef TDM_DEMUX_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] held;

  tdm_demux8 #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .dv    (dv),
    .sof   (sof),
    .y     (y),
    .yv    (yv),
    .yr    (yr),
    .s     (s),
    .err   (err),
`ifdef TDM_DEMUX_OVF_CNT_EN
    .ovf   (ovf),
    .ovf_cnt (ovf_cnt)
`else
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample #1 after the edge; a freshly loaded frame is checked against the scoreboard.
  task automatic step(input logic [7:0] dd, input logic ddv, input logic ssof, input logic yyr);
    logic pre_yv;
    logic [63:0] e;
    pre_yv = yv;
    d = dd; dv = ddv; sof = ssof; yr = yyr;
    @(posedge clk);
    #1;
    if (yv && (!pre_yv || yyr)) begin
      chk("sb_frame_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_frame_data", y, e);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input logic yyr, input logic push);
    logic [63:0] f;
    for (int i = 0; i < 8; i++) begin
      f[8*i +: 8] = base + 8'(i);
    end
    if (push) exp_q.push_back(f);
    for (int i = 0; i < 8; i++) begin
      step(base + 8'(i), 1'b1, (i == 0), yyr);
    end
  endtask

  initial begin
    rst_n = 1'b0; d = '0; dv = 1'b0; sof = 1'b0; yr = 1'b0;
    #3;
    chk("reset_yv", 64'(yv), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_y", y, 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
`ifdef TDM_DEMUX_OVF_CNT_EN
    chk("reset_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // basic frame with yr held high
    exp_q.push_back(64'h1716151413121110);
    step(8'h10, 1'b1, 1'b1, 1'b1);
    chk("first_sample_s", 64'(s), 64'd1);
    chk("first_sample_yv", 64'(yv), 64'd0);
    for (int i = 1; i < 8; i++) step(8'h10 + 8'(i), 1'b1, 1'b0, 1'b1);
    chk("basic_yv", 64'(yv), 64'd1);
    chk("basic_y", y, 64'h1716151413121110);
    chk("basic_s_wrap", 64'(s), 64'd0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("basic_yv_drop", 64'(yv), 64'd0);

    // samples before sof after a reset are ignored
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hAA, 1'b1, 1'b0, 1'b1);
    chk("unaligned_s_aa", 64'(s), 64'd0);
    step(8'hBB, 1'b1, 1'b0, 1'b1);
    chk("unaligned_s_bb", 64'(s), 64'd0);
    chk("unaligned_yv", 64'(yv), 64'd0);
    send_frame(8'h20, 1'b1, 1'b1);
    chk("aligned_yv", 64'(yv), 64'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1);

    // sof on the 4th sample realigns
    step(8'h30, 1'b1, 1'b1, 1'b1);
    step(8'h31, 1'b1, 1'b0, 1'b1);
    step(8'h32, 1'b1, 1'b0, 1'b1);
    chk("pre_realign_err", 64'(err), 64'd0);
    exp_q.push_back(64'h4746454443424140);
    step(8'h40, 1'b1, 1'b1, 1'b1);
    chk("realign_err", 64'(err), 64'd1);
    chk("realign_s", 64'(s), 64'd1);
    step(8'h41, 1'b1, 1'b0, 1'b1);
    chk("realign_err_1cyc", 64'(err), 64'd0);
    for (int i = 2; i < 8; i++) step(8'h40 + 8'(i), 1'b1, 1'b0, 1'b1);
    chk("realign_yv", 64'(yv), 64'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1);

    // back-to-back frames with yr low: second one is dropped
    send_frame(8'h50, 1'b0, 1'b1);
    held = 64'h5756555453525150;
    send_frame(8'h60, 1'b0, 1'b0);
    chk("drop_ovf", 64'(ovf), 64'd1);
    chk("drop_y_held", y, held);
    chk("drop_yv", 64'(yv), 64'd1);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf_1cyc", 64'(ovf), 64'd0);
    chk("drop_y_stable", y, held);
`ifdef TDM_DEMUX_OVF_CNT_EN
    chk("drop_ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("drop_consumed_yv", 64'(yv), 64'd0);
`ifdef TDM_DEMUX_OVF_CNT_EN
    chk("ovf_cnt_cleared", 64'(ovf_cnt), 64'd0);
`endif

    // completion coincides with consumption
    send_frame(8'h70, 1'b0, 1'b1);
    exp_q.push_back(64'h8786858483828180);
    step(8'h80, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) step(8'h80 + 8'(i), 1'b1, 1'b0, 1'b0);
    chk("swap_y_held", y, 64'h7776757473727170);
    step(8'h87, 1'b1, 1'b0, 1'b1);
    chk("swap_yv", 64'(yv), 64'd1);
    chk("swap_y", y, 64'h8786858483828180);
    chk("swap_no_ovf", 64'(ovf), 64'd0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("swap_drain_yv", 64'(yv), 64'd0);

    // async reset mid-frame with a frame pending
    send_frame(8'hC0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h90 + 8'(i), 1'b1, (i == 0), 1'b0);
    chk("pre_reset_s", 64'(s), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_yv", 64'(yv), 64'd0);
    chk("async_s", 64'(s), 64'd0);
    chk("async_y", y, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 5; i < 8; i++) step(8'h90 + 8'(i), 1'b1, 1'b0, 1'b1);
    chk("remainder_s", 64'(s), 64'd0);
    chk("remainder_yv", 64'(yv), 64'd0);
    send_frame(8'hB0, 1'b1, 1'b1);
    chk("post_reset_frame_yv", 64'(yv), 64'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Eight-slot time-division demultiplexer: the receive-side counterpart of the 8:1 select/mux path. It accepts a serial stream of W-bit samples with a start-of-frame marker, steers slot k into lane k, and presents each complete 8-lane frame as one parallel word under a valid/ready handshake. It sits downstream of an 8-channel TDM mux so that the eight original lanes can be recovered.

## Interface
- W, default 8, sample/lane width in bits (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- d  in  W  input sample
- dv  in  1  d valid this cycle; sample accepted on every edge where dv=1 (no backpressure on input)
- sof  in  1  start of frame; qualified by dv; marks d as slot 0
- y  out  8*W  frame output; lane k is y[W*k +: W]
- yv  out  1  y holds a complete, unconsumed frame
- yr  in  1  consumer ready; frame consumed on an edge where yv=1 and yr=1
- s  out  3  slot index the next accepted sample will occupy
- err  out  1  one-cycle pulse: frame alignment error
- ovf  out  1  one-cycle pulse: completed frame dropped (output busy)

## Operation
- States: IDLE (unaligned), COLLECT (aligned, slot counter s active).
- Reset: state=IDLE, s=0, y=0, yv=0, err=0, ovf=0, all lane staging registers 0.
- IDLE: samples with dv=1, sof=0 are discarded. dv=1, sof=1: d written to staging lane 0, s←1, go to COLLECT.
- COLLECT, dv=1, sof=0: d written to staging lane s, s←s+1 (3-bit wrap).
- COLLECT, dv=1, sof=1, s=0: normal; treated as slot 0.
- COLLECT, dv=1, sof=1, s≠0: err pulses next cycle, partial frame discarded, d written as slot 0, s←1 (realign; no return to IDLE).
- sof with dv=0 is ignored in every state.
- Frame completion: accepted sample at s=7. Staging lanes 0–6 plus d form the frame; s←0, stay in COLLECT. The next sample is slot 0 whether or not sof is asserted.
- On completion: if yv=0, or yv=1 and yr=1 on the same edge, y←new frame, yv←1. If yv=1 and yr=0, frame dropped, y unchanged, ovf pulses.
- Handshake: y stable while yv=1 and yr=0; yv falls after a consuming edge unless a new frame loads on that same edge.
- dv=0 cycles insert gaps anywhere; s and staging lanes hold.

## Timing
- Latency: the slot-7 sample accepted at edge N → y/yv valid after edge N (one registered stage).
- err and ovf are registered: asserted for exactly the one cycle after the causing edge.
- s updates on the accepting edge; it reads 0 in IDLE.
- Maximum throughput: one frame per 8 cycles with dv held 1 and yr held 1, no drops.
- rst_n assertion mid-frame clears everything immediately (asynchronous); after deassertion, the block is in IDLE and requires sof.

## Configuration
- TDM_DEMUX_OVF_CNT_EN defined: adds output ovf_cnt [7:0], a saturating count of dropped frames (stops at 255). It resets to 0 and is cleared by a consumed frame (yv & yr) on an edge with no simultaneous drop. A drop and a clear on the same edge leave ovf_cnt=1.
- Not defined: no ovf_cnt port and no counter logic; ovf pulse only.

## Test plan
- Reset then dv=1 on 8 samples 0x10..0x17 with sof on the first, yr=1 → after the 8th edge yv=1 and y=0x1716151413121110; yv=0 the following cycle.
- Samples 0xAA, 0xBB before any sof → ignored, s=0, no yv; the frame that follows with sof assembles correctly.
- sof asserted on the 4th sample of a frame → err pulses 1 cycle; that sample becomes lane 0 of the next completed frame.
- yr=0 and two full frames sent back to back → first frame held on y, ovf pulses once at the second frame's completion, y unchanged; with the macro defined, ovf_cnt=1.
- yv=1 and the next frame completes on the same edge as yr=1 → y takes the new frame, yv stays 1, no ovf.
- rst_n pulsed low after 5 samples → yv=0, s=0, y=0 immediately; the next frame requires sof, and a 3-sample remainder produces no output.
